// File: rtl/mac_mdc_engine.sv
// Two-stage multiply / shift / add-or-accumulate engine with a/b/c -> d streams.
// Build option: define MAC_MDC_ROUND_EN for round-half-up on the stage-1 shift.
module mac_mdc_engine #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     test_mode_i,
    input  logic                     clear_i,

    input  logic                     a_valid_i,
    input  logic signed [DATA_W-1:0] a_data_i,
    output logic                     a_ready_o,
    input  logic                     b_valid_i,
    input  logic signed [DATA_W-1:0] b_data_i,
    output logic                     b_ready_o,
    input  logic                     c_valid_i,
    input  logic signed [DATA_W-1:0] c_data_i,
    output logic                     c_ready_o,

    output logic                     d_valid_o,
    output logic signed [DATA_W-1:0] d_data_o,
    input  logic                     d_ready_i,

    input  logic                     ctrl_start_i,
    input  logic                     ctrl_clear_i,
    input  logic                     ctrl_enable_i,
    input  logic [CNT_W-1:0]         cnt_limit_i,

    input  logic                     simple_mul_i,
    input  logic [4:0]               shift_i,
    input  logic [CNT_W-1:0]         len_i,

    output logic                     flags_ready_o,
    output logic [CNT_W-1:0]         flags_cnt_o
);

    localparam int PW = 2 * DATA_W;

    logic                     unused_test_mode;
    assign unused_test_mode = test_mode_i;

    // Stage 1 registers
    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_p;
    logic signed [DATA_W-1:0] s1_c;
    logic                     s1_first;
    logic                     s1_last;

    // Stage 2 / accumulation state
    logic signed [DATA_W-1:0] acc;
    logic [CNT_W-1:0]         beat_cnt;
    logic [CNT_W-1:0]         cnt_q;

    logic                     clr;
    logic                     d_hs;
    logic                     s2_adv;
    logic                     s1_free;
    logic                     in_ready;
    logic                     accept;

    logic signed [PW-1:0]     a_ext;
    logic signed [PW-1:0]     b_ext;
    logic signed [PW-1:0]     prod;
    logic signed [DATA_W-1:0] p_next;

    logic [CNT_W-1:0]         len_eff;
    logic [CNT_W:0]           beat_nxt;
    logic                     beat_first;
    logic                     beat_last;

    logic signed [DATA_W-1:0] acc_base;
    logic signed [DATA_W-1:0] sum;

    assign clr      = clear_i | ctrl_clear_i;
    assign d_hs     = d_valid_o & d_ready_i;
    assign s2_adv   = s1_valid & (~d_valid_o | d_ready_i);
    assign s1_free  = ~s1_valid | s2_adv;
    // Readies are forced low while reset is held so nothing looks accepted.
    assign in_ready = rst_ni & ctrl_enable_i & a_valid_i & b_valid_i & c_valid_i & s1_free;
    assign accept   = in_ready & ~clr;

    assign a_ready_o = in_ready;
    assign b_ready_o = in_ready;
    assign c_ready_o = in_ready;

    assign flags_ready_o = ~s1_valid & ~d_valid_o & (beat_cnt == '0);
    assign flags_cnt_o   = cnt_q;

    assign a_ext = PW'(a_data_i);
    assign b_ext = PW'(b_data_i);
    assign prod  = a_ext * b_ext;

`ifdef MAC_MDC_ROUND_EN
    logic signed [PW-1:0] rnd;

    always_comb begin
        rnd = '0;
        if (shift_i != 5'd0) begin
            rnd[shift_i - 5'd1] = 1'b1;
        end
    end

    assign p_next = DATA_W'((prod + rnd) >>> shift_i);
`else
    assign p_next = DATA_W'(prod >>> shift_i);
`endif

    // Simple-mode beats are treated as one-beat groups so stage 2 has one datapath.
    assign len_eff    = (len_i == '0) ? CNT_W'(1) : len_i;
    assign beat_nxt   = {1'b0, beat_cnt} + 1'b1;
    assign beat_first = simple_mul_i | (beat_cnt == '0);
    assign beat_last  = simple_mul_i | (beat_nxt >= {1'b0, len_eff});

    assign acc_base = s1_first ? s1_c : acc;
    assign sum      = acc_base + s1_p;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_c      <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
            cnt_q     <= '0;
            d_valid_o <= 1'b0;
            d_data_o  <= '0;
        end else if (clr) begin
            s1_valid  <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
            cnt_q     <= '0;
            d_valid_o <= 1'b0;
            d_data_o  <= '0;
        end else begin
            if (d_hs && (cnt_q < cnt_limit_i)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (s2_adv) begin
                acc <= sum;
            end

            if (s2_adv && s1_last) begin
                d_valid_o <= 1'b1;
                d_data_o  <= sum;
            end else if (d_hs) begin
                d_valid_o <= 1'b0;
            end

            if (accept) begin
                s1_valid <= 1'b1;
                s1_p     <= p_next;
                s1_c     <= c_data_i;
                s1_first <= beat_first;
                s1_last  <= beat_last;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (ctrl_start_i && flags_ready_o) begin
                beat_cnt <= '0;
            end
            if (accept && !simple_mul_i) begin
                beat_cnt <= beat_last ? '0 : beat_nxt[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mac_mdc_engine.sv
// Directed self-checking bench for mac_mdc_engine (honours MAC_MDC_ROUND_EN if defined).
module tb_mac_mdc_engine;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     test_mode_i;
    logic                     clear_i;
    logic                     a_valid_i, b_valid_i, c_valid_i;
    logic signed [DATA_W-1:0] a_data_i, b_data_i, c_data_i;
    logic                     a_ready_o, b_ready_o, c_ready_o;
    logic                     d_valid_o;
    logic signed [DATA_W-1:0] d_data_o;
    logic                     d_ready_i;
    logic                     ctrl_start_i, ctrl_clear_i, ctrl_enable_i;
    logic [CNT_W-1:0]         cnt_limit_i;
    logic                     simple_mul_i;
    logic [4:0]               shift_i;
    logic [CNT_W-1:0]         len_i;
    logic                     flags_ready_o;
    logic [CNT_W-1:0]         flags_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_cnt  = 0;

    mac_mdc_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
        .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .c_valid_i(c_valid_i), .c_data_i(c_data_i), .c_ready_o(c_ready_o),
        .d_valid_o(d_valid_o), .d_data_o(d_data_o), .d_ready_i(d_ready_i),
        .ctrl_start_i(ctrl_start_i), .ctrl_clear_i(ctrl_clear_i), .ctrl_enable_i(ctrl_enable_i),
        .cnt_limit_i(cnt_limit_i), .simple_mul_i(simple_mul_i), .shift_i(shift_i),
        .len_i(len_i), .flags_ready_o(flags_ready_o), .flags_cnt_o(flags_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic set_valid(input logic v);
        a_valid_i = v;
        b_valid_i = v;
        c_valid_i = v;
    endtask

    // Presents one beat, waits (bounded) for acceptance, returns #1 after the accepting edge.
    task automatic beat(input int a, input int b, input int c, input logic simple,
                        input int sh, input int len);
        bit ok = 0;
        a_data_i     = a;
        b_data_i     = b;
        c_data_i     = c;
        simple_mul_i = simple;
        shift_i      = 5'(sh);
        len_i        = CNT_W'(len);
        set_valid(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (a_ready_o && b_ready_o && c_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk_i);
        #1;
        set_valid(1'b0);
    endtask

    task automatic pulse_clear;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        rst_ni        = 1'b0;
        test_mode_i   = 1'b0;
        clear_i       = 1'b0;
        set_valid(1'b1);
        a_data_i      = '0;
        b_data_i      = '0;
        c_data_i      = '0;
        d_ready_i     = 1'b1;
        ctrl_start_i  = 1'b0;
        ctrl_clear_i  = 1'b0;
        ctrl_enable_i = 1'b1;
        cnt_limit_i   = 16'd100;
        simple_mul_i  = 1'b1;
        shift_i       = '0;
        len_i         = 16'd1;

        // Reset values, readies held low despite valid inputs
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_d_valid", 64'(d_valid_o), 64'd0);
        check("rst_d_data", 64'(d_data_o), 64'd0);
        check("rst_ready", 64'(a_ready_o), 64'd0);
        check("rst_cnt", 64'(flags_cnt_o), 64'd0);
        check("rst_flags_ready", 64'(flags_ready_o), 64'd1);
        set_valid(1'b0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Enable low blocks acceptance
        ctrl_enable_i = 1'b0;
        set_valid(1'b1);
        @(negedge clk_i);
        check("enable_block", 64'({a_ready_o, b_ready_o, c_ready_o}), 64'd0);
        set_valid(1'b0);
        ctrl_enable_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Simple mode: 3 * -4 + 5 = -7
        beat(3, -4, 5, 1'b1, 0, 1);
        check("simple_lat1", 64'(d_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("simple_valid", 64'(d_valid_o), 64'd1);
        check("simple_data", d_data_o, -64'sd7);
        @(posedge clk_i);
        #1;
        exp_cnt++;
        check("simple_cnt", 64'(flags_cnt_o), 64'(exp_cnt));
        check("simple_drop", 64'(d_valid_o), 64'd0);

        // Shift by 1: +7 and -7
        beat(7, 1, 0, 1'b1, 1, 1);
        @(posedge clk_i);
        #1;
`ifdef MAC_MDC_ROUND_EN
        check("shift_pos", d_data_o, 64'sd4);
`else
        check("shift_pos", d_data_o, 64'sd3);
`endif
        beat(-7, 1, 0, 1'b1, 1, 1);
        @(posedge clk_i);
        #1;
`ifdef MAC_MDC_ROUND_EN
        check("shift_neg", d_data_o, -64'sd3);
`else
        check("shift_neg", d_data_o, -64'sd4);
`endif
        @(posedge clk_i);
        #1;
        exp_cnt += 2;

        // Accumulate len=4: 10 + 2 + 12 + 30 + 56 = 110
        beat(1, 2, 10, 1'b0, 0, 4);
        check("acc_b1_nod", 64'(d_valid_o), 64'd0);
        check("acc_busy", 64'(flags_ready_o), 64'd0);
        beat(3, 4, 99, 1'b0, 0, 4);
        check("acc_b2_nod", 64'(d_valid_o), 64'd0);
        beat(5, 6, -50, 1'b0, 0, 4);
        check("acc_b3_nod", 64'(d_valid_o), 64'd0);
        beat(7, 8, 1234, 1'b0, 0, 4);
        check("acc_b4_nod", 64'(d_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        check("acc_valid", 64'(d_valid_o), 64'd1);
        check("acc_data", d_data_o, 64'sd110);
        @(posedge clk_i);
        #1;
        exp_cnt++;
        check("acc_cnt", 64'(flags_cnt_o), 64'(exp_cnt));

        // Backpressure across three beats (results 1, 2, 3)
        d_ready_i = 1'b0;
        beat(1, 1, 0, 1'b1, 0, 1);
        beat(2, 1, 0, 1'b1, 0, 1);
        a_data_i = 3;
        b_data_i = 1;
        c_data_i = 0;
        set_valid(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_ready_low", 64'(a_ready_o), 64'd0);
            check("bp_hold", d_data_o, 64'sd1);
        end
        d_ready_i = 1'b1;
        #1;
        check("bp_ready_back", 64'(a_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        set_valid(1'b0);
        check("bp_second", d_data_o, 64'sd2);
        @(posedge clk_i);
        #1;
        check("bp_third", d_data_o, 64'sd3);
        @(posedge clk_i);
        #1;
        exp_cnt += 3;
        check("bp_cnt", 64'(flags_cnt_o), 64'(exp_cnt));
        check("bp_empty", 64'(d_valid_o), 64'd0);

        // ctrl_clear after beat 2 of a len=4 group
        beat(1, 2, 10, 1'b0, 0, 4);
        beat(3, 4, 0, 1'b0, 0, 4);
        ctrl_clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        ctrl_clear_i = 1'b0;
        exp_cnt = 0;
        check("clr_d_valid", 64'(d_valid_o), 64'd0);
        check("clr_cnt", 64'(flags_cnt_o), 64'd0);
        check("clr_flags_ready", 64'(flags_ready_o), 64'd1);
        ctrl_start_i = 1'b1;
        beat(1, 2, 10, 1'b0, 0, 4);
        ctrl_start_i = 1'b0;
        beat(3, 4, 0, 1'b0, 0, 4);
        beat(5, 6, 0, 1'b0, 0, 4);
        beat(7, 8, 0, 1'b0, 0, 4);
        @(posedge clk_i);
        #1;
        check("clr_next_data", d_data_o, 64'sd110);
        @(posedge clk_i);
        #1;
        exp_cnt++;

        // clear_i coinciding with an accept discards the beat
        a_data_i     = 9;
        b_data_i     = 9;
        c_data_i     = 9;
        simple_mul_i = 1'b1;
        set_valid(1'b1);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        set_valid(1'b0);
        clear_i = 1'b0;
        exp_cnt = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("clr_win_d_valid", 64'(d_valid_o), 64'd0);
        check("clr_win_cnt", 64'(flags_cnt_o), 64'd0);
        check("clr_win_ready", 64'(flags_ready_o), 64'd1);

        // Saturation at cnt_limit=2 with 5 outputs
        cnt_limit_i = 16'd2;
        for (int i = 0; i < 5; i++) begin
            beat(i, 1, 0, 1'b1, 0, 1);
            @(posedge clk_i);
            #1;
        end
        repeat (2) @(posedge clk_i);
        #1;
        check("sat_cnt", 64'(flags_cnt_o), 64'd2);

        // cnt_limit=0 keeps the count at zero
        pulse_clear();
        cnt_limit_i = 16'd0;
        beat(1, 1, 1, 1'b1, 0, 1);
        repeat (3) @(posedge clk_i);
        #1;
        check("lim0_cnt", 64'(flags_cnt_o), 64'd0);
        cnt_limit_i = 16'd100;

        // Reset mid-group: immediate reset values, no partial result afterwards
        beat(1, 2, 10, 1'b0, 0, 4);
        beat(3, 4, 0, 1'b0, 0, 4);
        set_valid(1'b1);
        rst_ni = 1'b0;
        #1;
        check("mrst_d_valid", 64'(d_valid_o), 64'd0);
        check("mrst_d_data", 64'(d_data_o), 64'd0);
        check("mrst_ready", 64'(a_ready_o), 64'd0);
        check("mrst_cnt", 64'(flags_cnt_o), 64'd0);
        check("mrst_flags_ready", 64'(flags_ready_o), 64'd1);
        set_valid(1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("mrst_no_emit", 64'(d_valid_o), 64'd0);
        check("mrst_idle", 64'(flags_ready_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
